ram_sdp_stream_fifo: RTL and testbench

//   Valid/ready streaming FIFO that owns both ports of one ram_sdp_one_clock:
//   the write side drives port A, and a read engine drives port B.
//   The read engine hides the RAM's 1-cycle registered read latency behind a
//   2-entry output skid buffer, giving first-word-fall-through at full rate.

---
 rtl/classifier_fifo_pkg.sv | 17 +
 rtl/ram_sdp_one_clock.sv | 37 +++
 rtl/ram_sdp_stream_fifo.sv | 145 ++++++++++++++
 tb/tb_ram_sdp_stream_fifo.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/classifier_fifo_pkg.sv
// Shared types and constants for the classifier stream FIFOs.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package classifier_fifo_pkg;

    localparam int FIFO_DEPTH  = 32;
    localparam int FIFO_AWIDTH = $clog2(FIFO_DEPTH);

    // Occupancy count wide enough to hold 0..FIFO_DEPTH inclusive
    typedef logic [FIFO_AWIDTH:0] fifo_cnt_t;

    // Output skid occupancy, 0..2
    typedef logic [1:0] skid_occ_t;

    localparam skid_occ_t SKID_DEPTH = 2'd2;

endpackage

// File: rtl/ram_sdp_one_clock.sv
// Simple dual-port RAM, one clock: port A writes, port B reads.
// Latency: dob is registered, valid the cycle after enb.
// Backpressure: none; caller schedules all accesses.
module ram_sdp_one_clock
    import classifier_fifo_pkg::*;
#(
    parameter  int DWIDTH = 64,
    parameter  int DEPTH  = 32,
    localparam int AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              ena,
    input  logic              wea,
    input  logic [AWIDTH-1:0] addra,
    input  logic [DWIDTH-1:0] dia,
    input  logic              enb,
    input  logic [AWIDTH-1:0] addrb,
    output logic [DWIDTH-1:0] dob
);

    logic [DWIDTH-1:0] mem [DEPTH];

    // Port A write; contents are never cleared
    always_ff @(posedge clk) begin
        if (ena && wea) begin
            mem[addra] <= dia;
        end
    end

    // Port B registered read
    always_ff @(posedge clk) begin
        if (enb) begin
            dob <= mem[addrb];
        end
    end

endmodule

// File: rtl/ram_sdp_stream_fifo.sv
// Valid/ready FWFT FIFO on one SDP RAM with a 2-entry output skid hiding read latency.
// Latency: push into empty FIFO in cycle N gives out_valid in N+3; 1 word/clk sustained.
// Backpressure: registered in_ready, deasserts at DEPTH words; independent of out_ready.
module ram_sdp_stream_fifo
    import classifier_fifo_pkg::*;
#(
    parameter  int DWIDTH = 64,
    parameter  int DEPTH  = 32,
    localparam int AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [AWIDTH:0]   count
);

    localparam int              CW      = AWIDTH + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [CW-1:0]     ram_occ;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_next;
    logic              rd_pend;
    logic              in_ready_q;
    skid_occ_t         skid_occ;
    logic              skid_hd;
    logic [DWIDTH-1:0] skid_q0;
    logic [DWIDTH-1:0] skid_q1;
    logic [DWIDTH-1:0] dob;
    logic              push;
    logic              pop;
    logic              issue;
    logic              capture;
    logic              skid_wr_sel;
    logic [2:0]        pend_after_pop;

    // Handshakes are ignored entirely during a flush cycle
    assign push      = in_valid & in_ready_q & ~flush;
    assign out_valid = (skid_occ != 2'd0);
    assign pop       = out_valid & out_ready & ~flush;

    // Only issue a read if the skid will have room for the returning word,
    // counting the word already in flight and the one leaving this cycle.
    assign pend_after_pop = {1'b0, skid_occ} + {2'b00, rd_pend} - {2'b00, pop};
    assign issue          = (ram_occ != '0) & (pend_after_pop < {1'b0, SKID_DEPTH}) & ~flush;

    // A flush discards the word returning from the RAM this cycle
    assign capture     = rd_pend & ~flush;
    assign skid_wr_sel = skid_hd ^ skid_occ[0];

    assign count_next = flush ? '0 : (count_q + CW'(push) - CW'(pop));

    assign in_ready = in_ready_q;
    assign count    = count_q;
    assign out_data = skid_hd ? skid_q1 : skid_q0;

    ram_sdp_one_clock #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .ena   (push),
        .wea   (push),
        .addra (wr_ptr),
        .dia   (in_data),
        .enb   (issue),
        .addrb (rd_ptr),
        .dob   (dob)
    );

    // RAM-side pointers, RAM occupancy and the outstanding-read flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_occ <= '0;
            rd_pend <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_occ <= '0;
            rd_pend <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AWIDTH'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + AWIDTH'(1);
            end
            ram_occ <= ram_occ + CW'(push) - CW'(issue);
            rd_pend <= issue;
        end
    end

    // Total occupancy and the registered accept flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            count_q    <= count_next;
            in_ready_q <= (count_next < DEPTH_C);
        end
    end

    // Two-register skid: capture returning RAM data at the tail, pop from the head
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            skid_q0  <= '0;
            skid_q1  <= '0;
            skid_hd  <= 1'b0;
            skid_occ <= '0;
        end else if (flush) begin
            skid_hd  <= 1'b0;
            skid_occ <= '0;
        end else begin
            if (capture) begin
                if (skid_wr_sel) begin
                    skid_q1 <= dob;
                end else begin
                    skid_q0 <= dob;
                end
            end
            if (pop) begin
                skid_hd <= ~skid_hd;
            end
            skid_occ <= skid_occ + skid_occ_t'(capture) - skid_occ_t'(pop);
        end
    end

    a_skid_bound : assert property (@(posedge clk) disable iff (!rstn)
        skid_occ <= SKID_DEPTH);

    a_count_sum : assert property (@(posedge clk) disable iff (!rstn)
        count_q == ram_occ + CW'(rd_pend) + CW'(skid_occ));

endmodule

// File: tb/tb_ram_sdp_stream_fifo.sv
// Self-checking bench for ram_sdp_stream_fifo with a queue-based reference model.
// Latency: n/a.
// Backpressure: drives random and directed out_ready stalls.
module tb_ram_sdp_stream_fifo;
    import classifier_fifo_pkg::*;

    localparam int DW = 64;

    logic          clk       = 1'b0;
    logic          rstn      = 1'b0;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    fifo_cnt_t     count;

    ram_sdp_stream_fifo #(
        .DWIDTH (DW),
        .DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: queue of accepted words plus the cycle each was accepted.
    // A word can be seen at the head no earlier than three cycles after its push.
    logic [63:0] mq[$];
    int          mt[$];
    int          cyc   = 0;
    bit          m_rdy = 1'b0;

    function automatic bit m_vld();
        return (mq.size() > 0) && (mt[0] + 3 <= cyc);
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
            mt.delete();
            m_rdy = 1'b0;
        end else begin
            if (flush) begin
                mq.delete();
                mt.delete();
            end else begin
                bit mpop;
                bit mpush;
                mpop  = out_ready && m_vld();
                mpush = in_valid && m_rdy;
                if (mpop) begin
                    void'(mq.pop_front());
                    void'(mt.pop_front());
                end
                if (mpush) begin
                    mq.push_back(in_data);
                    mt.push_back(cyc);
                end
            end
            m_rdy = (mq.size() < FIFO_DEPTH);
            cyc++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("out_valid", 64'(out_valid), 64'(m_vld()));
        if (m_vld()) chk("out_data", out_data, mq[0]);
        chk("count", 64'(count), 64'(mq.size()));
        chk("in_ready", 64'(in_ready), 64'(m_rdy));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset, release, then one word through an empty FIFO with literal expectations
    task automatic reset_and_basic();
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        repeat (3) step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        rstn = 1'b1;
        step();
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        repeat (8) step();
        in_valid = 1'b1;
        in_data  = 64'hA5;
        step();
        in_valid = 1'b0;
        chk("lat_n1_out_valid", 64'(out_valid), 64'd0);
        step();
        chk("lat_n2_out_valid", 64'(out_valid), 64'd0);
        step();
        chk("lat_n3_out_valid", 64'(out_valid), 64'd1);
        chk("lat_n3_out_data", out_data, 64'hA5);
        chk("lat_n3_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pop_count", 64'(count), 64'd0);
        chk("pop_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        int sent;
        int guard;
        bit acc;

        // Test 1: reset and single word
        reset_and_basic();

        // Test 2: fill to capacity with the consumer stalled, then drain across the wrap
        out_ready = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            step();
        end
        in_data = 64'h99;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_count", 64'(count), 64'd32);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("full_refuse_count", 64'(count), 64'd32);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            chk("drain_out_valid", 64'(out_valid), 64'd1);
            chk("drain_out_data", out_data, 64'(i));
            step();
        end
        out_ready = 1'b0;
        chk("drain_count", 64'(count), 64'd0);

        // Test 3: full-rate streaming
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(1000 + i);
            if (i == 500) begin
                chk("stream_count", 64'(count), 64'd3);
                chk("stream_out_valid", 64'(out_valid), 64'd1);
            end
            step();
        end
        in_valid = 1'b0;
        repeat (6) step();
        chk("stream_drain_count", 64'(count), 64'd0);
        out_ready = 1'b0;

        // Test 4: random handshakes
        sent  = 0;
        guard = 0;
        while (sent < 10000 && guard < 60000) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = {32'hC0DE_0000, 32'(sent)};
            acc       = in_valid && in_ready;
            step();
            if (acc) sent++;
            guard++;
        end
        chk("rand_words_sent", 64'(sent), 64'd10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) step();
        chk("rand_drain_count", 64'(count), 64'd0);
        out_ready = 1'b0;

        // Test 5: flush with a RAM read in flight
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h50 + 64'(i);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = 64'h77;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("post_flush_out_valid", 64'(out_valid), 64'd1);
        chk("post_flush_out_data", out_data, 64'h77);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Test 6: asynchronous reset mid-stream
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 64'h600 + 64'(i);
            step();
        end
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset_and_basic();

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
